// File: rtl/response_serializer_if.sv
// Handshake bundle between the register read port, the response serializer and the UART TX.
// The slave modport is the serializer's view; the master modport is the surrounding logic's view.
interface response_serializer_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int ADDR_WORDS  = 1,
  parameter int VALUE_WORDS = 4
);
  logic                              i_valid;
  logic                              o_ready;
  logic                              i_nack;
  logic [WORD_WIDTH*ADDR_WORDS-1:0]  i_addr;
  logic [WORD_WIDTH*VALUE_WORDS-1:0] i_value;
  logic [WORD_WIDTH-1:0]             o_tx_data;
  logic                              o_tx_valid;
  logic                              i_tx_ready;
  logic                              o_busy;

  modport slave (
    input  i_valid, i_nack, i_addr, i_value, i_tx_ready,
    output o_ready, o_tx_data, o_tx_valid, o_busy
  );

  modport master (
    output i_valid, i_nack, i_addr, i_value, i_tx_ready,
    input  o_ready, o_tx_data, o_tx_valid, o_busy
  );
endinterface

// File: rtl/response_serializer.sv
// Serializes one register-read response (header, address, value) or a single-word NACK
// into a byte stream for the UART transmitter, most significant word first.
module response_serializer #(
  parameter int                    WORD_WIDTH  = 8,
  parameter int                    ADDR_WORDS  = 1,
  parameter int                    VALUE_WORDS = 4,
  parameter logic [WORD_WIDTH-1:0] RESP_HDR    = 8'h52,
  parameter logic [WORD_WIDTH-1:0] NACK_HDR    = 8'h6E
) (
  input  logic                 clk,
  input  logic                 i_reset_n,
  response_serializer_if.slave bus
);

  localparam int FRAME_WORDS = 1 + ADDR_WORDS + VALUE_WORDS;
  localparam int FRAME_BITS  = WORD_WIDTH * FRAME_WORDS;
  localparam int CNT_W       = $clog2(FRAME_WORDS + 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [FRAME_BITS-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]        count, count_next;
  logic [CNT_W-1:0]        frame_len, len_next;
  logic                    last_word;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      frame_len <= '0;
    end else begin
      state     <= state_next;
      shift_reg <= shift_next;
      count     <= count_next;
      frame_len <= len_next;
    end
  end

  assign last_word = (count == frame_len - CNT_W'(1));

  // A NACK reuses the same shift path but stops after the header word.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    count_next = count;
    len_next   = frame_len;
    case (state)
      IDLE: begin
        if (bus.i_valid) begin
          shift_next = {(bus.i_nack ? NACK_HDR : RESP_HDR), bus.i_addr, bus.i_value};
          len_next   = bus.i_nack ? CNT_W'(1) : CNT_W'(FRAME_WORDS);
          count_next = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (bus.i_tx_ready) begin
          shift_next = {shift_reg[FRAME_BITS-WORD_WIDTH-1:0], {WORD_WIDTH{1'b0}}};
          count_next = count + CNT_W'(1);
          if (last_word) begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs come straight from registers, so they hold steady through any TX stall.
  assign bus.o_ready    = (state == IDLE);
  assign bus.o_tx_valid = (state == SEND);
  assign bus.o_busy     = (state == SEND);
  assign bus.o_tx_data  = shift_reg[FRAME_BITS-1 -: WORD_WIDTH];

endmodule

// File: tb/tb_response_serializer.sv
// Directed bench for response_serializer: frames, NACK, backpressure, back-to-back,
// input changes after accept, and asynchronous reset mid-frame.
module tb_response_serializer;

  localparam logic [7:0] RESP = 8'h52;
  localparam logic [7:0] NACK = 8'h6E;

  logic clk;
  logic i_reset_n;
  int   vec_count;
  int   miss_count;

  response_serializer_if #(.WORD_WIDTH(8), .ADDR_WORDS(1), .VALUE_WORDS(4)) bus ();

  response_serializer dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vec_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one response, then scrambles the inputs and drains the frame word by word,
  // holding i_tx_ready low for stall_cycles cycles on word index stall_word.
  task automatic applyStimulus(input string tag, input logic nack, input logic [7:0] addr,
                               input logic [31:0] value, input int stall_word,
                               input int stall_cycles);
    logic [47:0] frame;
    int          len;
    frame = {(nack ? NACK : RESP), addr, value};
    len   = nack ? 1 : 6;
    checkOutput({tag, "_ready"}, 64'(bus.o_ready), 64'd1);
    bus.i_valid    = 1'b1;
    bus.i_nack     = nack;
    bus.i_addr     = addr;
    bus.i_value    = value;
    bus.i_tx_ready = 1'b1;
    nextCycle();
    bus.i_valid = 1'b0;
    bus.i_nack  = ~nack;
    bus.i_addr  = ~addr;
    bus.i_value = ~value;
    for (int w = 0; w < len; w++) begin
      if (w == stall_word) begin
        bus.i_tx_ready = 1'b0;
        for (int s = 0; s < stall_cycles; s++) begin
          checkOutput({tag, "_stall_data"}, 64'(bus.o_tx_data), 64'(frame[47-8*w -: 8]));
          checkOutput({tag, "_stall_valid"}, 64'(bus.o_tx_valid), 64'd1);
          nextCycle();
        end
        bus.i_tx_ready = 1'b1;
      end
      checkOutput({tag, "_data"}, 64'(bus.o_tx_data), 64'(frame[47-8*w -: 8]));
      checkOutput({tag, "_valid"}, 64'(bus.o_tx_valid), 64'd1);
      checkOutput({tag, "_busy"}, 64'(bus.o_busy), 64'd1);
      checkOutput({tag, "_notready"}, 64'(bus.o_ready), 64'd0);
      nextCycle();
    end
    checkOutput({tag, "_end_valid"}, 64'(bus.o_tx_valid), 64'd0);
    checkOutput({tag, "_end_ready"}, 64'(bus.o_ready), 64'd1);
    checkOutput({tag, "_end_busy"}, 64'(bus.o_busy), 64'd0);
  endtask

  initial begin
    logic [47:0] exp_a;
    logic [47:0] exp_b;
    vec_count      = 0;
    miss_count     = 0;
    i_reset_n      = 1'b0;
    bus.i_valid    = 1'b0;
    bus.i_nack     = 1'b0;
    bus.i_addr     = '0;
    bus.i_value    = '0;
    bus.i_tx_ready = 1'b1;
    repeat (2) nextCycle();
    checkOutput("rst_valid", 64'(bus.o_tx_valid), 64'd0);
    checkOutput("rst_busy", 64'(bus.o_busy), 64'd0);
    checkOutput("rst_data", 64'(bus.o_tx_data), 64'd0);
    i_reset_n = 1'b1;
    nextCycle();
    checkOutput("rst_ready", 64'(bus.o_ready), 64'd1);
    checkOutput("idle_txready_valid", 64'(bus.o_tx_valid), 64'd0);

    // 1: plain read response, also exercises inputs changing after accept
    applyStimulus("read", 1'b0, 8'h12, 32'h12345678, -1, 0);
    // 2: NACK is header only
    applyStimulus("nack", 1'b1, 8'hFF, 32'hCAFEF00D, -1, 0);
    // 3: backpressure on word index 1 (the address word)
    applyStimulus("bp", 1'b0, 8'h21, 32'h87654321, 1, 3);
    // 5: another frame with a different value and a stall on the last word
    applyStimulus("chg", 1'b0, 8'hA5, 32'h0BADBEEF, 5, 2);

    // 4: back-to-back with i_valid held high
    exp_a = {RESP, 8'h3C, 32'hA1B2C3D4};
    exp_b = {RESP, 8'h4D, 32'h55AA33CC};
    bus.i_valid    = 1'b1;
    bus.i_nack     = 1'b0;
    bus.i_addr     = 8'h3C;
    bus.i_value    = 32'hA1B2C3D4;
    bus.i_tx_ready = 1'b1;
    nextCycle();
    bus.i_addr  = 8'h4D;
    bus.i_value = 32'h55AA33CC;
    for (int w = 0; w < 6; w++) begin
      checkOutput("b2b_a_data", 64'(bus.o_tx_data), 64'(exp_a[47-8*w -: 8]));
      checkOutput("b2b_a_valid", 64'(bus.o_tx_valid), 64'd1);
      nextCycle();
    end
    checkOutput("b2b_gap_valid", 64'(bus.o_tx_valid), 64'd0);
    checkOutput("b2b_gap_ready", 64'(bus.o_ready), 64'd1);
    nextCycle();
    bus.i_valid = 1'b0;
    for (int w = 0; w < 6; w++) begin
      checkOutput("b2b_b_data", 64'(bus.o_tx_data), 64'(exp_b[47-8*w -: 8]));
      checkOutput("b2b_b_valid", 64'(bus.o_tx_valid), 64'd1);
      nextCycle();
    end
    checkOutput("b2b_end_valid", 64'(bus.o_tx_valid), 64'd0);

    // 6: reset asserted after three words have been taken
    bus.i_valid = 1'b1;
    bus.i_addr  = 8'h12;
    bus.i_value = 32'h12345678;
    nextCycle();
    bus.i_valid = 1'b0;
    repeat (3) nextCycle();
    checkOutput("mid_word3", 64'(bus.o_tx_data), 64'h34);
    #2;
    i_reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.o_tx_valid), 64'd0);
    checkOutput("mid_rst_busy", 64'(bus.o_busy), 64'd0);
    nextCycle();
    i_reset_n = 1'b1;
    nextCycle();
    checkOutput("post_rst_valid", 64'(bus.o_tx_valid), 64'd0);
    applyStimulus("post_rst", 1'b0, 8'h12, 32'h12345678, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
